// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one-stage valid/ready pipeline register.
// With SKID_EN=1 it holds up to two entries (main + skid), so in_ready depends
// only on state. With SKID_EN=0 it holds one entry and in_ready passes out_ready.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake (out_data = head entry)
//   flush_i                 drops every held entry and any offered input
//   occupancy_o             held entries (0..2)
//   stall_cnt_o             saturating count of cycles with out_valid & !out_ready
//   flush_cnt_o             saturating count of entries dropped by flush
module pipe_skid_stage #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned SKID_EN = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush_i,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              in_fire;
   logic              out_fire;
   logic [SUM_W-1:0]  flush_sum;

   // Handshake outputs: flush masks both sides in the same cycle.
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      occupancy_o = 2'd0;
      case (state)
         EMPTY: occupancy_o = 2'd0;
         FULL:  occupancy_o = 2'd1;
         SKID:  occupancy_o = 2'd2;
         default: occupancy_o = 2'd0;
      endcase
      if (!flush_i) begin
         case (state)
            EMPTY: in_ready = 1'b1;
            FULL: begin
               out_valid = 1'b1;
               // Without a skid slot, space only exists if the head leaves now.
               in_ready  = (SKID_EN != 0) ? 1'b1 : out_ready;
            end
            SKID: out_valid = 1'b1;
            default: begin
               in_ready  = 1'b0;
               out_valid = 1'b0;
            end
         endcase
      end
   end

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_q;
   assign flush_sum = {1'b0, flush_cnt_o} + SUM_W'(occupancy_o);

   // State and counters; reset outranks flush, flush outranks handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= EMPTY;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (flush_i) begin
         state       <= EMPTY;
         flush_cnt_o <= flush_sum[CNT_W] ? CNT_MAX : flush_sum[CNT_W-1:0];
      end else begin
         if (out_valid && !out_ready && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
         case (state)
            EMPTY: if (in_fire) state <= FULL;
            FULL: begin
               if (in_fire && !out_fire) begin
                  state <= SKID;
               end else if (out_fire && !in_fire) begin
                  state <= EMPTY;
               end
            end
            SKID: if (out_fire) state <= FULL;
            default: state <= EMPTY;
         endcase
      end
   end

   // Payload storage; left unreset since state qualifies every read.
   always_ff @(posedge clk) begin
      case (state)
         EMPTY: if (in_fire) main_q <= in_data;
         FULL: begin
            if (in_fire && out_fire) begin
               main_q <= in_data;
            end else if (in_fire) begin
               skid_q <= in_data;
            end
         end
         SKID: if (out_fire) main_q <= skid_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: drives two stage instances with shared stimulus
// (u_skid: SKID_EN=1, CNT_W=16; u_flow: SKID_EN=0, CNT_W=4) and checks them
// against a FIFO-with-capacity reference model through a negedge monitor.
module tb_pipe_skid_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;
   logic        flush;

   logic        rdy [2];
   logic        vld [2];
   logic [15:0] dat [2];
   logic [1:0]  occ [2];
   logic [15:0] stc [2];
   logic [15:0] flc [2];
   logic [3:0]  stc_flow;
   logic [3:0]  flc_flow;

   int unsigned n_cmp;
   int unsigned n_bad;

   pipe_skid_stage #(.DATA_W(16), .SKID_EN(1), .CNT_W(16)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[0]), .out_valid(vld[0]), .out_data(dat[0]),
      .out_ready(out_ready), .flush_i(flush), .occupancy_o(occ[0]),
      .stall_cnt_o(stc[0]), .flush_cnt_o(flc[0])
   );

   pipe_skid_stage #(.DATA_W(16), .SKID_EN(0), .CNT_W(4)) u_flow (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy[1]), .out_valid(vld[1]), .out_data(dat[1]),
      .out_ready(out_ready), .flush_i(flush), .occupancy_o(occ[1]),
      .stall_cnt_o(stc_flow), .flush_cnt_o(flc_flow)
   );

   assign stc[1] = 16'(stc_flow);
   assign flc[1] = 16'(flc_flow);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int inst,
                        input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard monitor ----------------
   logic [15:0] ent     [2][2];
   int unsigned m_cnt   [2];
   int unsigned m_stall [2];
   int unsigned m_flush [2];
   int unsigned cap     [2];
   int unsigned cmax    [2];
   logic        prev_hold [2];
   logic [15:0] prev_dat  [2];
   bit          model_on;

   initial begin
      cap[0] = 2;  cap[1] = 1;
      cmax[0] = 65535; cmax[1] = 15;
      model_on = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_stall[i] = 0; m_flush[i] = 0; prev_hold[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit e_vld;
         bit e_rdy;
         int unsigned sum;
         e_vld = !flush && (m_cnt[i] != 0);
         // Room exists if below capacity, or if the head is leaving this cycle
         // in the no-skid variant.
         e_rdy = !flush && ((m_cnt[i] < cap[i]) ||
                            (cap[i] == 1 && m_cnt[i] == 1 && out_ready));
         if (model_on) begin
            check("out_valid", i, 32'(vld[i]), 32'(e_vld));
            check("in_ready", i, 32'(rdy[i]), 32'(e_rdy));
            check("occupancy", i, 32'(occ[i]), m_cnt[i]);
            check("stall_cnt", i, 32'(stc[i]), m_stall[i]);
            check("flush_cnt", i, 32'(flc[i]), m_flush[i]);
            if (e_vld) check("order", i, 32'(dat[i]), 32'(ent[i][0]));
            if (prev_hold[i] && vld[i]) check("hold", i, 32'(dat[i]), 32'(prev_dat[i]));
         end
         prev_hold[i] = rst_n && !flush && vld[i] && !out_ready;
         prev_dat[i]  = dat[i];
         if (!rst_n) begin
            m_cnt[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
         end else if (flush) begin
            sum = m_flush[i] + m_cnt[i];
            m_flush[i] = (sum > cmax[i]) ? cmax[i] : sum;
            m_cnt[i] = 0;
         end else begin
            if (e_vld && !out_ready && m_stall[i] < cmax[i]) m_stall[i]++;
            if (e_vld && out_ready) begin
               ent[i][0] = ent[i][1];
               m_cnt[i]--;
            end
            if (in_valid && e_rdy) begin
               ent[i][m_cnt[i]] = in_data;
               m_cnt[i]++;
            end
         end
      end
      if (!rst_n) model_on = 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input logic v, input logic [15:0] d, input logic r,
                         input logic f, input logic rs);
      in_valid = v; in_data = d; out_ready = r; flush = f; rst_n = rs;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(2);
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [15:0] prev;
      n_cmp = 0;
      n_bad = 0;
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(3);

      // Reset state
      for (int i = 0; i < 2; i++) begin
         check("rst_occ", i, 32'(occ[i]), 32'd0);
         check("rst_valid", i, 32'(vld[i]), 32'd0);
         check("rst_ready", i, 32'(rdy[i]), 32'd1);
         check("rst_stall", i, 32'(stc[i]), 32'd0);
         check("rst_flush", i, 32'(flc[i]), 32'd0);
      end

      // Single transfer of 0xA5
      set_in(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b1);
      step(1);
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("a5_valid", i, 32'(vld[i]), 32'd1);
         check("a5_data", i, 32'(dat[i]), 32'h00A5);
         check("a5_occ", i, 32'(occ[i]), 32'd1);
      end
      step(1);
      set_in(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      step(1);

      // Skid fill under backpressure, then ordered drain
      do_reset();
      set_in(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
      #1;
      check("skid_occ", 0, 32'(occ[0]), 32'd2);
      check("skid_ready", 0, 32'(rdy[0]), 32'd0);
      step(3);
      check("skid_stall", 0, 32'(stc[0]), 32'd4);
      check("flow_stall", 1, 32'(stc[1]), 32'd4);
      set_in(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      #1;
      check("drain_first", 0, 32'(dat[0]), 32'h0011);
      step(1);
      check("drain_second", 0, 32'(dat[0]), 32'h0022);
      check("drain_second_v", 0, 32'(vld[0]), 32'd1);
      step(1);
      check("drain_empty", 0, 32'(vld[0]), 32'd0);
      check("drain_stall", 0, 32'(stc[0]), 32'd4);

      // Flush while holding two entries
      do_reset();
      set_in(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0044, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0055, 1'b1, 1'b1, 1'b1);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("flush_ready", i, 32'(rdy[i]), 32'd0);
         check("flush_valid", i, 32'(vld[i]), 32'd0);
      end
      step(1);
      set_in(1'b1, 16'h0056, 1'b0, 1'b0, 1'b1);
      #1;
      check("flush_cnt2", 0, 32'(flc[0]), 32'd2);
      check("flush_cnt1", 1, 32'(flc[1]), 32'd1);
      for (int i = 0; i < 2; i++) begin
         check("post_flush_occ", i, 32'(occ[i]), 32'd0);
         check("post_flush_ready", i, 32'(rdy[i]), 32'd1);
      end

      // 4-bit stall counter saturation
      do_reset();
      set_in(1'b1, 16'h0066, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(20);
      check("sat_stall", 1, 32'(stc[1]), 32'd15);
      check("wide_stall", 0, 32'(stc[0]), 32'd20);
      step(3);
      check("sat_hold", 1, 32'(stc[1]), 32'd15);
      check("wide_stall2", 0, 32'(stc[0]), 32'd23);

      // No-skid variant: ready follows out_ready, one transfer per cycle
      do_reset();
      set_in(1'b1, 16'h0077, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0078, 1'b0, 1'b0, 1'b1);
      #1;
      check("flow_ready_lo", 1, 32'(rdy[1]), 32'd0);
      set_in(1'b1, 16'h0078, 1'b1, 1'b0, 1'b1);
      #1;
      check("flow_ready_hi", 1, 32'(rdy[1]), 32'd1);
      step(1);
      prev = 16'h0078;
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, 16'h0080 + 16'(k), 1'b1, 1'b0, 1'b1);
         #1;
         check("tput_valid", 1, 32'(vld[1]), 32'd1);
         check("tput_data", 1, 32'(dat[1]), 32'(prev));
         prev = 16'h0080 + 16'(k);
         step(1);
      end

      // Reset while holding two entries
      do_reset();
      set_in(1'b1, 16'h0031, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b1, 16'h0032, 1'b0, 1'b0, 1'b1);
      step(1);
      set_in(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      step(1);
      set_in(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      #1;
      check("rst_mid_valid", 0, 32'(vld[0]), 32'd0);
      check("rst_mid_occ", 0, 32'(occ[0]), 32'd0);
      check("rst_mid_flush", 0, 32'(flc[0]), 32'd0);
      step(1);

      // Random traffic
      for (int c = 0; c < 10000; c++) begin
         set_in(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) < 5,
                ($urandom % 64) == 0, ($urandom % 512) != 0);
         step(1);
      end

      set_in(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      step(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 64: width of the stage payload in bits, legal range 1..1024.
REQ-002 Parameter SKID_EN, default 1: 1 selects a two-entry skid stage; 0 selects a single-entry stage with combinational ready.
REQ-003 Parameter CNT_W, default 16: width of each performance counter, legal range 4..32.
REQ-004 Port clk  input  1  sole clock; every flop updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-006 Port in_valid  input  1  upstream offers in_data this cycle.
REQ-007 Port in_data  input  DATA_W  upstream payload.
REQ-008 Port in_ready  output  1  stage accepts in_data this cycle.
REQ-009 Port out_valid  output  1  out_data holds a valid entry.
REQ-010 Port out_data  output  DATA_W  head-entry payload.
REQ-011 Port out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 Port flush_i  input  1  discards all held entries.
REQ-013 Port occupancy_o  output  2  number of held entries, 0..2.
REQ-014 Port stall_cnt_o  output  CNT_W  saturating count of backpressure cycles.
REQ-015 Port flush_cnt_o  output  CNT_W  saturating count of entries discarded by flush.

Function
REQ-016 Define in_fire = in_valid & in_ready, and out_fire = out_valid & out_ready.
REQ-017 The stage has three states: EMPTY (0 entries), FULL (main entry only) and SKID (main and skid entries); occupancy_o equals 0, 1 or 2 respectively.
REQ-018 In EMPTY: out_valid=0 and in_ready=1; an in_fire loads main and moves to FULL.
REQ-019 In FULL with SKID_EN=1: in_ready=1.
REQ-020 In FULL, in_fire & out_fire reloads main with in_data and stays in FULL.
REQ-021 In FULL, in_fire & !out_fire loads skid with in_data and moves to SKID.
REQ-022 In FULL, out_fire & !in_fire moves to EMPTY.
REQ-023 In SKID: in_ready=0; an out_fire copies skid to main and moves to FULL.
REQ-024 With SKID_EN=1, in_ready is a function of state only, with no combinational path from out_ready.
REQ-025 With SKID_EN=0, SKID is unreachable and in_ready = (state==EMPTY) | out_ready in FULL; FULL with in_valid & !out_ready holds main unchanged.
REQ-026 out_valid = 1 in FULL and SKID, and out_data = main.
REQ-027 While out_valid & !out_ready, out_data shall remain bit-stable on the next cycle.
REQ-028 Entries leave in acceptance order; there is no loss and no duplication.
REQ-029 flush_i has priority over all handshake activity: in_ready=0 and out_valid=0 combinationally, and the next state is EMPTY.
REQ-030 Data offered by upstream during a flush cycle is dropped.
REQ-031 stall_cnt_o increments by 1 in each cycle with out_valid & !out_ready & !flush_i, and saturates at 2^CNT_W-1.
REQ-032 On a flush cycle, flush_cnt_o increases by the current occupancy (0, 1 or 2) and saturates at 2^CNT_W-1, with no wrap.
REQ-033 Payload registers are not reset; only state and counters are reset.

Reset
REQ-034 While rst_n=0 at a clock edge, the next state is EMPTY: occupancy_o=0, out_valid=0, in_ready=1, stall_cnt_o=0 and flush_cnt_o=0.
REQ-035 Reset asserted mid-transfer in SKID discards both entries, and no out_fire occurs in the following cycle.
REQ-036 Reset has priority over flush_i and over all handshakes.

Verification
REQ-037 Reset, then in_valid=1 with in_data=0xA5 and out_ready=1 -> out_valid=1 and out_data=0xA5 on the next cycle, occupancy_o=1.
REQ-038 SKID_EN=1: hold out_ready=0 and send 0x11 then 0x22 -> occupancy_o=2 and in_ready=0; release out_ready -> 0x11 then 0x22 in order; stall_cnt_o counts the stalled cycles exactly.
REQ-039 In SKID, assert flush_i for one cycle -> occupancy_o=0, flush_cnt_o increases by 2, and in_ready=1 on the next cycle.
REQ-040 CNT_W=4: hold backpressure for 20 cycles -> stall_cnt_o=15 and stays at 15.
REQ-041 SKID_EN=0: FULL with out_ready=0 -> in_ready=0; toggle out_ready=1 -> in_ready=1 in the same cycle, throughput 1 per cycle.
REQ-042 Random valid/ready/flush traffic of 10k cycles against a scoreboard -> zero ordering mismatches and no data change under stall.
